ccip_batch_transmitter: RTL
===========================

CCIP_BATCH_TRANSMITTER -- requirements
Module: ccip_batch_transmitter

Interface
REQ-001 Parameter NIC_ID, default 0, NIC index used in simulation messages only.
REQ-002 Parameter LMAX_NUM_OF_FLOWS, default 1, log2 of the flow count; MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS.
REQ-003 Parameter LFIFO_DEPTH, default 3, log2 of the per-flow FIFO depth in RPC entries.
REQ-004 Parameter LTIMEOUT, default 8, width of the partial-batch timeout value.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- number_of_flows  in  LMAX_NUM_OF_FLOWS  highest active flow index.
- tx_base_addr  in  t_ccip_clAddr  host ring base, in cache lines.
- l_tx_batch_size  in  LMAX_CCIP_BATCH  log2 of the batch size (0/1/2).
- timeout_cycles  in  LTIMEOUT  partial-flush age; 0 disables flushing.
- start  in  1  enables accepting RPCs.
- sRx_c1TxAlmFull  in  1  CCI-P c1 almost-full.
- sTx_c1  out  t_if_ccip_c1_Tx  write requests.
- ccip_tx_ready  out  1  equals ~sRx_c1TxAlmFull.
- rpc_in  in  $bits(RpcIf)  RPC payload.
- rpc_in_valid  in  1  payload valid.
- rpc_flow_id_in  in  LMAX_NUM_OF_FLOWS  destination flow.
- pdrop_tx_flows_out  out  1  one-cycle pulse per dropped RPC.
- tx_lines_out  out  32  total lines issued, wrapping.

Function
REQ-006 Each flow SHALL own a synchronous FIFO of 2**LFIFO_DEPTH RpcIf entries with an occupancy count.
REQ-007 Push: start && rpc_in_valid && rpc_flow_id_in <= number_of_flows && that FIFO not full -> write the RPC at the next edge.
REQ-008 Push with the target FIFO full, or with flow id > number_of_flows, SHALL drop the RPC and assert pdrop_tx_flows_out on the following cycle.
REQ-009 A push and a pop on the same flow in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-010 Effective batch B = 2**min(l_tx_batch_size,2); the value 3 is treated as 2. B SHALL be latched only on entry to TX_BATCH or TX_FLUSH.
REQ-011 Per-flow age counter: cleared while the FIFO is empty and on every pop; otherwise increments by 1 per cycle, saturating at its maximum.
REQ-012 Scheduler FSM states: IDLE, TX_BATCH, TX_FLUSH; round-robin pointer ptr.
REQ-013 IDLE, with sRx_c1TxAlmFull=0 and count[ptr] >= B -> TX_BATCH.
REQ-014 IDLE, with sRx_c1TxAlmFull=0, 0 < count[ptr] < B, timeout_cycles != 0 and age[ptr] >= timeout_cycles -> TX_FLUSH, line count K = count[ptr].
REQ-015 IDLE, neither condition met -> ptr advances by 1, wrapping from number_of_flows to 0.
REQ-016 TX_BATCH/TX_FLUSH SHALL pop one entry per cycle for B (resp. K) cycles, ignoring almost-full once started, then return to IDLE with ptr advanced as in REQ-015.
REQ-017 Each popped entry SHALL appear on sTx_c1 with valid=1 exactly 2 cycles after its pop.
REQ-018 Header: req_type eREQ_WRLINE_I, vc_sel eVC_VH0, address = tx_base_addr + (flow << log2 B) + line index i (0-based); all other fields 0.
REQ-019 TX_BATCH lines: cl_len = encoding of B, sop=1 only for i=0. TX_FLUSH lines: cl_len eCL_LEN_1, sop=1 for every line.
REQ-020 sTx_c1.data low $bits(RpcIf) bits = RPC, remaining bits 0; valid=0 on every cycle not covered by REQ-017.
REQ-021 tx_lines_out SHALL increment by 1 for each valid line.
REQ-022 number_of_flows changes SHALL take effect at the next IDLE pointer advance; FIFOs of flows beyond it keep their contents and are not served.

Reset
REQ-023 On reset assertion, immediately and asynchronously: sTx_c1.valid=0, pdrop_tx_flows_out=0, tx_lines_out=0, all FIFO counts/ages=0, state IDLE, ptr=0.
REQ-024 Reset during TX_BATCH/TX_FLUSH SHALL abort the burst; no further lines are emitted and FIFO contents are discarded.

Verification
REQ-025 l=1, flows=2, base=0x1000, push 2 RPCs to flow 1 -> two lines at 0x1002/0x1003, cl_len eCL_LEN_2, sop 1 then 0, consecutive cycles.
REQ-026 l=2, timeout=10, push 3 RPCs to flow 0 -> after age reaches 10, three eCL_LEN_1 lines at 0x1000..0x1002, each with sop=1.
REQ-027 LFIFO_DEPTH=3, start=1, 9 pushes to a flow while almost-full held -> 9th RPC dropped, a single pdrop pulse, 8 entries retained.
REQ-028 Flows 0 and 1 both holding a full batch of 4 -> flow 0 served first, then flow 1, with no flow served twice in a row.
REQ-029 Assert reset on the 2nd line of a 4-line batch -> valid low in the same cycle; after release no lines are emitted and tx_lines_out=0.

Source files
------------

// File: rtl/ccip_batch_transmitter.sv
// CCI-P batch transmitter: per-flow RPC FIFOs drained round-robin onto the c1 write
// channel, either as full batches or as timed-out partial flushes of single lines.
module ccip_batch_transmitter #(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFIFO_DEPTH       = 3,
  parameter int LTIMEOUT          = 8,
  parameter int LMAX_CCIP_BATCH   = 2,
  parameter int RPC_WIDTH         = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
  input  logic [41:0]                   tx_base_addr,
  input  logic [LMAX_CCIP_BATCH-1:0]    l_tx_batch_size,
  input  logic [LTIMEOUT-1:0]           timeout_cycles,
  input  logic                          start,
  input  logic                          sRx_c1TxAlmFull,
  // t_if_ccip_c1_Tx packed: hdr[592:513], data[512:1], valid[0]
  output logic [592:0]                  sTx_c1,
  output logic                          ccip_tx_ready,
  input  logic [RPC_WIDTH-1:0]          rpc_in,
  input  logic                          rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  rpc_flow_id_in,
  output logic                          pdrop_tx_flows_out,
  output logic [31:0]                   tx_lines_out
);

  localparam int NF    = 2 ** LMAX_NUM_OF_FLOWS;
  localparam int DEPTH = 2 ** LFIFO_DEPTH;
  localparam int FW    = LMAX_NUM_OF_FLOWS;
  localparam int AW    = LMAX_NUM_OF_FLOWS + LFIFO_DEPTH;
  localparam int CW    = (LFIFO_DEPTH + 1 > 3) ? LFIFO_DEPTH + 1 : 3;

  localparam logic [3:0] REQ_WRLINE_I = 4'h0;
  localparam logic [1:0] VC_VH0       = 2'h2;
  localparam logic [1:0] CL_LEN_1     = 2'h0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TX_BATCH = 2'd1,
    TX_FLUSH = 2'd2
  } state_t;

  // NIC_ID only tags simulation messages; it has no hardware effect.
  if (NIC_ID < 0) begin : g_nic_id_unused
  end

  state_t                 state_reg;
  logic [FW-1:0]          ptr_reg;
  logic [FW-1:0]          flow_reg;
  logic [1:0]             lb_reg;
  logic [CW-1:0]          total_reg;
  logic [CW-1:0]          idx_reg;

  logic [CW-1:0]          count_vec  [NF];
  logic [LTIMEOUT-1:0]    age_vec    [NF];
  logic [LFIFO_DEPTH-1:0] wr_ptr_vec [NF];
  logic [LFIFO_DEPTH-1:0] rd_ptr_vec [NF];

  logic [RPC_WIDTH-1:0]   mem [2**AW];
  logic [RPC_WIDTH-1:0]   rd_data_reg;

  logic                   s1_valid_reg;
  logic                   s1_sop_reg;
  logic [1:0]             s1_cl_len_reg;
  logic [41:0]            s1_addr_reg;
  logic                   pdrop_reg;
  logic [31:0]            tx_lines_reg;

  logic [1:0]             lb_now;
  logic [CW-1:0]          b_now;
  logic                   push_req;
  logic                   push;
  logic                   drop;
  logic                   pop;
  logic [CW-1:0]          cur_count;
  logic [LTIMEOUT-1:0]    cur_age;
  logic                   go_batch;
  logic                   go_flush;
  logic [FW-1:0]          ptr_next;

  assign ccip_tx_ready      = ~sRx_c1TxAlmFull;
  assign pdrop_tx_flows_out = pdrop_reg;
  assign tx_lines_out       = tx_lines_reg;

  // Batch sizes above 4 lines are not supported by the channel; clamp to 4.
  assign lb_now = (l_tx_batch_size > LMAX_CCIP_BATCH'(2)) ? 2'd2 : l_tx_batch_size[1:0];
  assign b_now  = CW'(1) << lb_now;

  assign push_req = start && rpc_in_valid;
  assign push     = push_req && (rpc_flow_id_in <= number_of_flows) &&
                    (count_vec[rpc_flow_id_in] != CW'(DEPTH));
  assign drop     = push_req && !push;
  assign pop      = (state_reg != IDLE);

  assign cur_count = count_vec[ptr_reg];
  assign cur_age   = age_vec[ptr_reg];
  assign go_batch  = !sRx_c1TxAlmFull && (cur_count >= b_now);
  assign go_flush  = !sRx_c1TxAlmFull && (cur_count != '0) && (cur_count < b_now) &&
                     (timeout_cycles != '0) && (cur_age >= timeout_cycles);
  assign ptr_next  = (ptr_reg >= number_of_flows) ? '0 : ptr_reg + FW'(1);

  for (genvar gi = 0; gi < NF; gi++) begin : g_flow
    logic                   push_here;
    logic                   pop_here;
    logic [CW-1:0]          count_reg;
    logic [LTIMEOUT-1:0]    age_reg;
    logic [LFIFO_DEPTH-1:0] wr_ptr_reg;
    logic [LFIFO_DEPTH-1:0] rd_ptr_reg;

    assign push_here = push && (rpc_flow_id_in == FW'(gi));
    assign pop_here  = pop && (flow_reg == FW'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_reg  <= '0;
        age_reg    <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_here && !pop_here) begin
          count_reg <= count_reg + CW'(1);
        end else if (pop_here && !push_here) begin
          count_reg <= count_reg - CW'(1);
        end
        if (push_here) begin
          wr_ptr_reg <= wr_ptr_reg + LFIFO_DEPTH'(1);
        end
        if (pop_here) begin
          rd_ptr_reg <= rd_ptr_reg + LFIFO_DEPTH'(1);
        end
        if (pop_here || (count_reg == '0)) begin
          age_reg <= '0;
        end else if (age_reg != '1) begin
          age_reg <= age_reg + LTIMEOUT'(1);
        end
      end
    end

    assign count_vec[gi]  = count_reg;
    assign age_vec[gi]    = age_reg;
    assign wr_ptr_vec[gi] = wr_ptr_reg;
    assign rd_ptr_vec[gi] = rd_ptr_reg;
  end

  // All flows share one RAM addressed {flow, slot}: at most one push and one pop per cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[{rpc_flow_id_in, wr_ptr_vec[rpc_flow_id_in]}] <= rpc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      rd_data_reg <= mem[{flow_reg, rd_ptr_vec[flow_reg]}];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      flow_reg  <= '0;
      lb_reg    <= '0;
      total_reg <= '0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          idx_reg <= '0;
          if (go_batch) begin
            state_reg <= TX_BATCH;
            flow_reg  <= ptr_reg;
            lb_reg    <= lb_now;
            total_reg <= b_now;
          end else if (go_flush) begin
            state_reg <= TX_FLUSH;
            flow_reg  <= ptr_reg;
            lb_reg    <= lb_now;
            total_reg <= cur_count;
          end else begin
            ptr_reg <= ptr_next;
          end
        end
        default: begin
          idx_reg <= idx_reg + CW'(1);
          if (idx_reg == total_reg - CW'(1)) begin
            state_reg <= IDLE;
            ptr_reg   <= ptr_next;
          end
        end
      endcase
    end
  end

  // Header fields travel alongside the RAM read so both reach the output stage together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_sop_reg    <= 1'b0;
      s1_cl_len_reg <= '0;
      s1_addr_reg   <= '0;
      pdrop_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= pop;
      pdrop_reg    <= drop;
      if (pop) begin
        s1_addr_reg <= tx_base_addr + (42'(flow_reg) << lb_reg) + 42'(idx_reg);
        s1_sop_reg  <= (state_reg == TX_FLUSH) || (idx_reg == '0);
        s1_cl_len_reg <= (state_reg == TX_FLUSH) ? CL_LEN_1
                                                 : {lb_reg[1], lb_reg[1] | lb_reg[0]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sTx_c1       <= '0;
      tx_lines_reg <= '0;
    end else begin
      sTx_c1 <= '0;
      if (s1_valid_reg) begin
        sTx_c1[592:513] <= {6'b0, VC_VH0, s1_sop_reg, 1'b0, s1_cl_len_reg, REQ_WRLINE_I,
                            6'b0, s1_addr_reg, 16'b0};
        sTx_c1[512:1]   <= {{(512 - RPC_WIDTH){1'b0}}, rd_data_reg};
        sTx_c1[0]       <= 1'b1;
        tx_lines_reg    <= tx_lines_reg + 32'd1;
      end
    end
  end

endmodule
